// File: rtl/rot_share_pkg.sv
// rot_share_pkg: shared widths, clog2 helper and the stage-1 command record for rot_share_arbiter.
package rot_share_pkg;
    localparam int ROT_W   = 8;
    localparam int SHIFT_W = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) if ((1 << r) < v) r++;
        return r;
    endfunction

    // Sized for the largest supported NREQ (8) so the record is parameter-free.
    localparam int ID_MAX_W = clog2(8);

    typedef struct packed {
        logic [ROT_W-1:0]    data;
        logic [SHIFT_W-1:0]  shift;
        logic [ID_MAX_W-1:0] id;
    } cmd_t;
endpackage

// File: rtl/circular_shifter_8.sv
// circular_shifter_8: combinational 8-bit rotate-left by 0..7.
module circular_shifter_8 (
    input  logic [7:0] data_i,
    input  logic [2:0] shift_i,
    output logic [7:0] data_o
);
    logic [15:0] dbl;
    assign dbl    = {data_i, data_i} << shift_i;
    assign data_o = dbl[15:8];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i, with wrap-around.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        // Scan from farthest to nearest so the closest request to ptr_i wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr_i) + k) % NREQ;
            if (en_i && req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/rot_share_arbiter.sv
// rot_share_arbiter: round-robin sharing of one 8-bit rotator among NREQ requesters,
// with a command register and a result register and an id-tagged response channel.
module rot_share_arbiter
    import rot_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [ROT_W*NREQ-1:0]   req_data,
    input  logic [SHIFT_W*NREQ-1:0] req_shift,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ROT_W-1:0]        rsp_data,
    output logic [IDW-1:0]          rsp_id
);
    logic             adv1, adv2, acc;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gidx, rr_q, rr_d;
    cmd_t             s1_q, s1_d;
    logic             s1_v_q, s2_v_q;
    logic [ROT_W-1:0] sh_out, s2_data_q;
    logic [IDW-1:0]   s2_id_q;
    logic             unused_id;

    assign adv2 = !s2_v_q || rsp_ready;
    assign adv1 = !s1_v_q || adv2;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (req_valid),
        .en_i  (adv1),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    assign req_ready = gnt;
    assign acc       = |gnt;

    always_comb begin
        s1_d = s1_q;
        rr_d = rr_q;
        if (acc) begin
            s1_d.data  = req_data[int'(gidx)*ROT_W +: ROT_W];
            s1_d.shift = req_shift[int'(gidx)*SHIFT_W +: SHIFT_W];
            s1_d.id    = ID_MAX_W'(gidx);
            rr_d       = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        end
    end

    circular_shifter_8 u_rot (
        .data_i  (s1_q.data),
        .shift_i (s1_q.shift),
        .data_o  (sh_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_id_q   <= '0;
            rr_q      <= '0;
        end else begin
            if (adv1) s1_v_q <= acc;
            s1_q <= s1_d;
            rr_q <= rr_d;
            if (adv2) begin
                s2_v_q    <= s1_v_q;
                s2_data_q <= sh_out;
                s2_id_q   <= s1_q.id[IDW-1:0];
            end
        end
    end

    // Upper id bits are spare when NREQ is small.
    assign unused_id = ^s1_q.id;

    assign rsp_valid = s2_v_q;
    assign rsp_data  = s2_data_q;
    assign rsp_id    = s2_id_q;
endmodule

// File: tb/tb_rot_share_arbiter.sv
// tb_rot_share_arbiter: table vectors, directed corner sequences and a random run against a queue-based model.
module tb_rot_share_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [15:0] req_data;
    logic [5:0]  req_shift;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic [0:0]  rsp_id;

    int passed = 0;
    int total  = 0;

    rot_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shift (req_shift),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int rot(input int d, input int s);
        return ((d << s) | (d >> (8 - s))) & 255;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [2:0] s0,
                         input logic [7:0] d1, input logic [2:0] s1);
        req_valid = v;
        req_data  = {d1, d0};
        req_shift = {s1, s0};
    endtask

    typedef struct {
        logic [1:0] v;
        logic [7:0] d0;
        logic [2:0] s0;
        logic [7:0] d1;
        logic [2:0] s1;
        logic [1:0] ery;
        logic       erv;
        logic [7:0] ed;
        logic       ei;
    } vec_t;

    vec_t tv[$];

    logic       pend [2];
    logic [7:0] pd   [2];
    logic [2:0] ps   [2];
    int         qd[$], qi[$];
    int         mrr, eg, idx;

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive(2'b00, 8'h00, 3'd0, 8'h00, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        rst_n = 1'b1;

        // single command, shift sweep on req1, then 6-accept contention
        tv.push_back('{2'b01, 8'hAF, 3'd1, 8'h00, 3'd0, 2'b01, 1'b0, 8'h00, 1'b0});
        tv.push_back('{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 2'b00, 1'b0, 8'h00, 1'b0});
        tv.push_back('{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 2'b00, 1'b1, 8'h5F, 1'b0});
        tv.push_back('{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 2'b00, 1'b0, 8'h00, 1'b0});
        tv.push_back('{2'b10, 8'h00, 3'd0, 8'hAF, 3'd0, 2'b10, 1'b0, 8'h00, 1'b0});
        tv.push_back('{2'b10, 8'h00, 3'd0, 8'hAF, 3'd1, 2'b10, 1'b0, 8'h00, 1'b0});
        tv.push_back('{2'b10, 8'h00, 3'd0, 8'hAF, 3'd2, 2'b10, 1'b1, 8'hAF, 1'b1});
        tv.push_back('{2'b10, 8'h00, 3'd0, 8'hAF, 3'd3, 2'b10, 1'b1, 8'h5F, 1'b1});
        tv.push_back('{2'b10, 8'h00, 3'd0, 8'hAF, 3'd4, 2'b10, 1'b1, 8'hBE, 1'b1});
        tv.push_back('{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 2'b00, 1'b1, 8'h7D, 1'b1});
        tv.push_back('{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 2'b00, 1'b1, 8'hFA, 1'b1});
        tv.push_back('{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 2'b00, 1'b0, 8'h00, 1'b0});
        tv.push_back('{2'b11, 8'h01, 3'd1, 8'h80, 3'd1, 2'b01, 1'b0, 8'h00, 1'b0});
        tv.push_back('{2'b11, 8'h01, 3'd1, 8'h80, 3'd1, 2'b10, 1'b0, 8'h00, 1'b0});
        tv.push_back('{2'b11, 8'h01, 3'd1, 8'h80, 3'd1, 2'b01, 1'b1, 8'h02, 1'b0});
        tv.push_back('{2'b11, 8'h01, 3'd1, 8'h80, 3'd1, 2'b10, 1'b1, 8'h01, 1'b1});
        tv.push_back('{2'b11, 8'h01, 3'd1, 8'h80, 3'd1, 2'b01, 1'b1, 8'h02, 1'b0});
        tv.push_back('{2'b11, 8'h01, 3'd1, 8'h80, 3'd1, 2'b10, 1'b1, 8'h01, 1'b1});
        tv.push_back('{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 2'b00, 1'b1, 8'h02, 1'b0});
        tv.push_back('{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 2'b00, 1'b1, 8'h01, 1'b1});
        tv.push_back('{2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 2'b00, 1'b0, 8'h00, 1'b0});

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].v, tv[i].d0, tv[i].s0, tv[i].d1, tv[i].s1);
            #1;
            chk($sformatf("tbl%0d_req_ready", i), req_ready, tv[i].ery);
            chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tv[i].erv);
            if (tv[i].erv) begin
                chk($sformatf("tbl%0d_rsp_data", i), rsp_data, tv[i].ed);
                chk($sformatf("tbl%0d_rsp_id", i), rsp_id, tv[i].ei);
            end
        end

        // backpressure: two accepted, third held until rsp_ready rises
        @(negedge clk); rsp_ready = 1'b0; drive(2'b01, 8'h11, 3'd1, 8'h00, 3'd0);
        #1 chk("bp_acc1", req_ready, 1);
        @(negedge clk); drive(2'b01, 8'h33, 3'd0, 8'h00, 3'd0);
        #1 chk("bp_acc2", req_ready, 1);
        @(negedge clk); drive(2'b01, 8'h44, 3'd4, 8'h00, 3'd0);
        #1 chk("bp_full_ready", req_ready, 0);
        chk("bp_full_valid", rsp_valid, 1);
        chk("bp_full_data", rsp_data, 8'h22);
        chk("bp_full_id", rsp_id, 0);
        @(negedge clk);
        #1 chk("bp_hold_ready", req_ready, 0);
        chk("bp_hold_data", rsp_data, 8'h22);
        @(negedge clk); rsp_ready = 1'b1;
        #1 chk("bp_same_cycle_accept", req_ready, 1);
        chk("bp_drain1", rsp_data, 8'h22);
        @(negedge clk); drive(2'b00, 8'h00, 3'd0, 8'h00, 3'd0);
        #1 chk("bp_drain2_valid", rsp_valid, 1);
        chk("bp_drain2", rsp_data, 8'h33);
        @(negedge clk);
        #1 chk("bp_drain3_valid", rsp_valid, 1);
        chk("bp_drain3", rsp_data, rot(8'h44, 4));
        @(negedge clk);
        #1 chk("bp_empty", rsp_valid, 0);

        // reset with both stages full
        @(negedge clk); rsp_ready = 1'b0; drive(2'b10, 8'h00, 3'd0, 8'h55, 3'd0);
        #1 chk("rst_fill1", req_ready, 2);
        @(negedge clk); drive(2'b10, 8'h00, 3'd0, 8'h66, 3'd1);
        #1 chk("rst_fill2", req_ready, 2);
        @(negedge clk);
        #1 chk("rst_full_ready", req_ready, 0);
        chk("rst_full_valid", rsp_valid, 1);
        rst_n = 1'b0;
        drive(2'b11, 8'h01, 3'd0, 8'h02, 3'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst_after_valid", rsp_valid, 0);
        chk("rst_after_data", rsp_data, 0);
        chk("rst_idle_grant", req_ready, 1);
        drive(2'b00, 8'h00, 3'd0, 8'h00, 3'd0);
        rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1 chk("rst_no_ghost", rsp_valid, 0);
        end

        // idle: rr must survive cycles with no accept
        @(negedge clk); drive(2'b01, 8'h0F, 3'd0, 8'h00, 3'd0);
        #1 chk("idle_pre_accept", req_ready, 1);
        @(negedge clk); drive(2'b00, 8'h00, 3'd0, 8'h00, 3'd0);
        repeat (3) @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            #1 chk("idle_rsp_valid", rsp_valid, 0);
        end
        drive(2'b11, 8'h00, 3'd0, 8'h00, 3'd0);
        #1 chk("idle_rr_kept", req_ready, 2);
        drive(2'b00, 8'h00, 3'd0, 8'h00, 3'd0);

        // random traffic against a queue model
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mrr = 0;
        for (int i = 0; i < 2; i++) pend[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    pd[i]   = 8'($urandom);
                    ps[i]   = 3'($urandom);
                end
            drive({pend[1], pend[0]}, pd[0], ps[0], pd[1], ps[1]);
            rsp_ready = ($urandom_range(3, 0) != 0);
            #1;
            eg = 0;
            if (!(qd.size() == 2 && !rsp_ready))
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (mrr + k) % NREQ;
                    if (eg == 0 && pend[j]) eg = 1 << j;
                end
            chk("rnd_grant", req_ready, eg);
            if (rsp_valid && rsp_ready) begin
                if (qd.size() == 0) chk("rnd_spurious_rsp", rsp_valid, 0);
                else begin
                    chk("rnd_rsp_data", rsp_data, qd.pop_front());
                    chk("rnd_rsp_id", rsp_id, qi.pop_front());
                end
            end
            if (eg != 0) begin
                idx = (eg == 2) ? 1 : 0;
                qd.push_back(rot(pd[idx], ps[idx]));
                qi.push_back(idx);
                pend[idx] = 1'b0;
                mrr = (idx + 1) % NREQ;
            end
        end
        @(negedge clk);
        drive(2'b00, 8'h00, 3'd0, 8'h00, 3'd0);
        rsp_ready = 1'b1;
        repeat (4) begin
            #1;
            if (rsp_valid) begin
                if (qd.size() == 0) chk("drain_spurious_rsp", rsp_valid, 0);
                else begin
                    chk("drain_rsp_data", rsp_data, qd.pop_front());
                    chk("drain_rsp_id", rsp_id, qi.pop_front());
                end
            end
            @(negedge clk);
        end
        chk("drain_all_returned", qd.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
